qspi_psram_emu: RTL and testbench

- Synthesizable, parametrised PSRAM emulator that replaces the behavioural RAM model in FPGA and gate-level benches.
- Oversamples the serial bus (SCK, CSn, IO[3:0]) on one system clock.
- Supports SPI and QPI modes, quad read/write, SPI read/write and the reset-enable/reset sequence.
- Adds configurable depth and read latency.

---
 rtl/qspi_psram_emu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_qspi_psram_emu.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_emu.sv
// qspi_psram_emu: a synthesizable PSRAM emulator for FPGA and gate-level benches.
// It oversamples SCK, CSn and IO[3:0] on CLK and serves SPI/QPI reads and writes
// from an internal byte memory. It also handles the QPI enter/exit and the
// reset-enable/reset command pair.
module qspi_psram_emu #(
   parameter int ADDR_BITS    = 16,
   parameter int WAIT_CYCLES  = 3,
   parameter bit QPI_AT_RESET = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCK,
   input  logic       CSn,
   input  logic [3:0] IO_IN,
   output logic [3:0] IO_OUT,
   output logic [3:0] IO_OE,
   output logic       QUAD_MODE,
   output logic       BUSY
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
   localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

   localparam logic [7:0] OP_ENTER_QPI = 8'h35;
   localparam logic [7:0] OP_EXIT_QPI  = 8'hF5;
   localparam logic [7:0] OP_RST_EN    = 8'h66;
   localparam logic [7:0] OP_RST       = 8'h99;
   localparam logic [7:0] OP_QREAD     = 8'hEB;
   localparam logic [7:0] OP_SREAD     = 8'h03;
   localparam logic [7:0] OP_QWRITE    = 8'h38;
   localparam logic [7:0] OP_SWRITE    = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WAIT,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_t;

   // Input synchronisers
   logic [1:0] sckSync_q;
   logic [1:0] csnSync_q;
   logic       sckPrev_q;
   logic [3:0] ioMeta_q;
   logic [3:0] ioSync_q;

   // Protocol state
   state_t                state_q;
   logic [7:0]            shift_q;
   logic [2:0]            bitCnt_q;
   logic [7:0]            cmd_q;
   logic                  cmdDone_q;
   logic                  isRead_q;
   logic                  needWait_q;
   logic [15:0]           addrShift_q;
   logic [1:0]            addrCnt_q;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [3:0]            waitCnt_q;
   logic [7:0]            txShift_q;
   logic [2:0]            outCnt_q;
   logic                  armed_q;
   logic                  rstEn_q;
   logic                  quad_q;
   logic                  busy_q;
   logic [3:0]            ioOut_q;
   logic [3:0]            ioOe_q;

   // Memory
   logic [7:0]            mem_q [0:DEPTH-1];
   logic [7:0]            memRd_q;

   // Decoded helpers
   logic        sckRise;
   logic        sckFall;
   logic        csnHigh;
   logic [7:0]  shiftIn_d;
   logic        byteDone;
   logic [23:0] fullAddr_d;
   logic [7:0]  txByte_d;
   logic        txLast;
   logic        memWe;

   assign sckRise    = sckSync_q[1] & ~sckPrev_q;
   assign sckFall    = ~sckSync_q[1] & sckPrev_q;
   assign csnHigh    = csnSync_q[1];
   assign shiftIn_d  = quad_q ? {shift_q[3:0], ioSync_q} : {shift_q[6:0], ioSync_q[0]};
   assign byteDone   = sckRise && (quad_q ? (bitCnt_q == 3'd1) : (bitCnt_q == 3'd7));
   assign fullAddr_d = {addrShift_q, shiftIn_d};
   assign txByte_d   = (outCnt_q == 3'd0) ? memRd_q : txShift_q;
   assign txLast     = quad_q ? (outCnt_q == 3'd1) : (outCnt_q == 3'd7);
   assign memWe      = (state_q == ST_WDATA) && !csnHigh && byteDone;

   assign IO_OUT    = ioOut_q;
   assign IO_OE     = ioOe_q;
   assign QUAD_MODE = quad_q;
   assign BUSY      = busy_q;

   // Bring SCK, CSn and IO into the CLK domain; IO shares the SCK depth so data lines up with edges
   always_ff @(posedge CLK) begin
      if (RST) begin
         sckSync_q <= 2'b00;
         csnSync_q <= 2'b11;
         sckPrev_q <= 1'b0;
         ioMeta_q  <= 4'h0;
         ioSync_q  <= 4'h0;
      end else begin
         sckSync_q <= {sckSync_q[0], SCK};
         csnSync_q <= {csnSync_q[0], CSn};
         sckPrev_q <= sckSync_q[1];
         ioMeta_q  <= IO_IN;
         ioSync_q  <= ioMeta_q;
      end
   end

   // Byte memory: one write from the write burst and one registered read that follows addr_q
   always_ff @(posedge CLK) begin
      if (memWe) begin
         mem_q[addr_q] <= shiftIn_d;
      end
      memRd_q <= mem_q[addr_q];
   end

   // Transaction FSM: command/address shifting, read/write bursts, mode changes on CSn rise
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         shift_q     <= 8'h00;
         bitCnt_q    <= 3'd0;
         cmd_q       <= 8'h00;
         cmdDone_q   <= 1'b0;
         isRead_q    <= 1'b0;
         needWait_q  <= 1'b0;
         addrShift_q <= 16'h0000;
         addrCnt_q   <= 2'd0;
         addr_q      <= '0;
         waitCnt_q   <= 4'd0;
         txShift_q   <= 8'h00;
         outCnt_q    <= 3'd0;
         armed_q     <= 1'b0;
         rstEn_q     <= 1'b0;
         quad_q      <= QPI_AT_RESET;
         busy_q      <= 1'b0;
         ioOut_q     <= 4'h0;
         ioOe_q      <= 4'h0;
      end else begin
         busy_q <= ~csnHigh;
         if (csnHigh) begin
            armed_q <= 1'b1;
            if (state_q != ST_IDLE && cmdDone_q) begin
               case (cmd_q)
                  OP_ENTER_QPI: begin
                     quad_q  <= 1'b1;
                     rstEn_q <= 1'b0;
                  end
                  OP_EXIT_QPI: begin
                     quad_q  <= 1'b0;
                     rstEn_q <= 1'b0;
                  end
                  OP_RST_EN: begin
                     rstEn_q <= 1'b1;
                  end
                  OP_RST: begin
                     if (rstEn_q) begin
                        quad_q <= 1'b0;
                     end
                     rstEn_q <= 1'b0;
                  end
                  default: begin
                     rstEn_q <= 1'b0;
                  end
               endcase
            end
            state_q   <= ST_IDLE;
            ioOut_q   <= 4'h0;
            ioOe_q    <= 4'h0;
            bitCnt_q  <= 3'd0;
            cmdDone_q <= 1'b0;
         end else begin
            if (sckRise && (state_q inside {ST_CMD, ST_ADDR, ST_WDATA})) begin
               shift_q  <= shiftIn_d;
               bitCnt_q <= byteDone ? 3'd0 : bitCnt_q + 3'd1;
            end
            case (state_q)
               ST_IDLE: begin
                  if (armed_q) begin
                     state_q   <= ST_CMD;
                     bitCnt_q  <= 3'd0;
                     addrCnt_q <= 2'd0;
                     outCnt_q  <= 3'd0;
                     waitCnt_q <= 4'd0;
                  end
               end
               ST_CMD: begin
                  if (byteDone) begin
                     cmd_q     <= shiftIn_d;
                     cmdDone_q <= 1'b1;
                     addrCnt_q <= 2'd0;
                     if (quad_q && shiftIn_d == OP_QREAD) begin
                        isRead_q   <= 1'b1;
                        needWait_q <= 1'b1;
                        state_q    <= ST_ADDR;
                     end else if (!quad_q && shiftIn_d == OP_SREAD) begin
                        isRead_q   <= 1'b1;
                        needWait_q <= 1'b0;
                        state_q    <= ST_ADDR;
                     end else if ((quad_q && shiftIn_d == OP_QWRITE) ||
                                  (!quad_q && shiftIn_d == OP_SWRITE)) begin
                        isRead_q   <= 1'b0;
                        needWait_q <= 1'b0;
                        state_q    <= ST_ADDR;
                     end else begin
                        state_q <= ST_IGNORE;
                     end
                  end
               end
               ST_ADDR: begin
                  if (byteDone) begin
                     addrShift_q <= {addrShift_q[7:0], shiftIn_d};
                     addrCnt_q   <= addrCnt_q + 2'd1;
                     if (addrCnt_q == 2'd2) begin
                        addr_q    <= fullAddr_d[ADDR_BITS-1:0];
                        waitCnt_q <= 4'd0;
                        outCnt_q  <= 3'd0;
                        if (!isRead_q) begin
                           state_q <= ST_WDATA;
                        end else if (needWait_q) begin
                           state_q <= ST_WAIT;
                        end else begin
                           state_q <= ST_RDATA;
                        end
                     end
                  end
               end
               ST_WAIT: begin
                  if (sckRise) begin
                     if (waitCnt_q == WAIT_LAST) begin
                        state_q <= ST_RDATA;
                     end else begin
                        waitCnt_q <= waitCnt_q + 4'd1;
                     end
                  end
               end
               ST_RDATA: begin
                  if (sckFall) begin
                     if (quad_q) begin
                        ioOe_q    <= 4'hF;
                        ioOut_q   <= txByte_d[7:4];
                        txShift_q <= {txByte_d[3:0], 4'h0};
                     end else begin
                        ioOe_q    <= 4'b0010;
                        ioOut_q   <= {2'b00, txByte_d[7], 1'b0};
                        txShift_q <= {txByte_d[6:0], 1'b0};
                     end
                     if (txLast) begin
                        outCnt_q <= 3'd0;
                        addr_q   <= addr_q + ADDR_ONE;
                     end else begin
                        outCnt_q <= outCnt_q + 3'd1;
                     end
                  end
               end
               ST_WDATA: begin
                  if (byteDone) begin
                     addr_q <= addr_q + ADDR_ONE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qspi_psram_emu.sv
// Directed bench for qspi_psram_emu: three instances differing only in read latency
// (3, 1 and 15 dummy cycles) share one serial bus driven by the controller tasks below.
module tb_qspi_psram_emu;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SCK = 1'b0;
   logic       CSn = 1'b1;
   logic [3:0] IO_IN = 4'h0;

   logic [3:0] ioOut [3];
   logic [3:0] ioOe [3];
   logic       quadMode [3];
   logic       busy [3];

   int   assertCount = 0;
   int   failCount = 0;
   logic qpi = 1'b0;

   logic [3:0] smpOut [3];
   logic [3:0] smpOe [3];
   logic [3:0] preOe [3];
   logic [3:0] capOut [3][32];
   logic [3:0] capOe [3][32];

   logic [31:0] rdData;
   logic        oeOk;
   logic [3:0]  oeOr;
   int          w;

   qspi_psram_emu #(.ADDR_BITS(16), .WAIT_CYCLES(3), .QPI_AT_RESET(1'b0)) dutW3 (
      .CLK(CLK), .RST(RST), .SCK(SCK), .CSn(CSn), .IO_IN(IO_IN),
      .IO_OUT(ioOut[0]), .IO_OE(ioOe[0]), .QUAD_MODE(quadMode[0]), .BUSY(busy[0]));

   qspi_psram_emu #(.ADDR_BITS(16), .WAIT_CYCLES(1), .QPI_AT_RESET(1'b0)) dutW1 (
      .CLK(CLK), .RST(RST), .SCK(SCK), .CSn(CSn), .IO_IN(IO_IN),
      .IO_OUT(ioOut[1]), .IO_OE(ioOe[1]), .QUAD_MODE(quadMode[1]), .BUSY(busy[1]));

   qspi_psram_emu #(.ADDR_BITS(16), .WAIT_CYCLES(15), .QPI_AT_RESET(1'b0)) dutW15 (
      .CLK(CLK), .RST(RST), .SCK(SCK), .CSn(CSn), .IO_IN(IO_IN),
      .IO_OUT(ioOut[2]), .IO_OE(ioOe[2]), .QUAD_MODE(quadMode[2]), .BUSY(busy[2]));

   // System clock
   always #5 CLK = ~CLK;

   // Safety net in case the run stalls
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int waitOf(input int d);
      if (d == 0) return 3;
      if (d == 1) return 1;
      return 15;
   endfunction

   function automatic logic [31:0] nibbles(input int d, input int start, input int n);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r = {r[27:0], capOut[d][start+k]};
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One SCK period: data set up, rise, fall, then sample 3 CLK after the fall
   task automatic applyStimulus(input logic [3:0] d);
      IO_IN = d;
      @(negedge CLK);
      SCK = 1'b1;
      repeat (2) @(negedge CLK);
      SCK = 1'b0;
      repeat (3) @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         smpOut[i] = ioOut[i];
         smpOe[i]  = ioOe[i];
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      if (qpi) begin
         applyStimulus(b[7:4]);
         applyStimulus(b[3:0]);
      end else begin
         for (int i = 7; i >= 0; i--) applyStimulus({3'b000, b[i]});
      end
   endtask

   task automatic sendAddr(input logic [23:0] a);
      sendByte(a[23:16]);
      sendByte(a[15:8]);
      sendByte(a[7:0]);
   endtask

   task automatic beginTxn();
      CSn = 1'b0;
      repeat (3) @(negedge CLK);
   endtask

   task automatic endTxn();
      CSn = 1'b1;
      repeat (4) @(negedge CLK);
   endtask

   task automatic singleCmd(input logic [7:0] op);
      beginTxn();
      sendByte(op);
      endTxn();
   endtask

   task automatic spiRead(input int nBits, output logic [31:0] data, output logic ok);
      data = {31'b0, smpOut[0][1]};
      ok = (smpOe[0] == 4'b0010);
      for (int k = 1; k < nBits; k++) begin
         applyStimulus(4'h0);
         data = {data[30:0], smpOut[0][1]};
         if (smpOe[0] != 4'b0010) ok = 1'b0;
      end
   endtask

   task automatic quadRead(input logic [23:0] a, input int nUnits);
      beginTxn();
      sendByte(8'hEB);
      sendAddr(a);
      for (int i = 0; i < 3; i++) preOe[i] = smpOe[i];
      for (int u = 0; u < nUnits; u++) begin
         applyStimulus(4'h0);
         for (int i = 0; i < 3; i++) begin
            capOut[i][u] = smpOut[i];
            capOe[i][u]  = smpOe[i];
         end
      end
      endTxn();
   endtask

   task automatic quadWrite(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
      beginTxn();
      sendByte(8'h38);
      sendAddr(a);
      sendByte(b0);
      sendByte(b1);
      endTxn();
   endtask

   initial begin
      $display("[TB] start");
      repeat (4) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("reset_oe", ioOe[0], 4'h0);
      checkOutput("reset_out", ioOut[0], 4'h0);
      checkOutput("reset_quad", quadMode[0], 1'b0);
      checkOutput("reset_busy", busy[0], 1'b0);
      repeat (3) @(negedge CLK);

      // SPI write A5 3C at 0x10
      beginTxn();
      checkOutput("busy_low_csn", busy[0], 1'b1);
      sendByte(8'h02);
      sendAddr(24'h000010);
      sendByte(8'hA5);
      sendByte(8'h3C);
      endTxn();
      checkOutput("busy_idle", busy[0], 1'b0);

      // SPI read back
      beginTxn();
      sendByte(8'h03);
      checkOutput("spi_oe_cmd", smpOe[0], 4'h0);
      sendAddr(24'h000010);
      spiRead(16, rdData, oeOk);
      endTxn();
      checkOutput("spi_read_data", rdData, 32'h0000A53C);
      checkOutput("spi_read_oe", oeOk, 1'b1);
      checkOutput("spi_oe_after", ioOe[0], 4'h0);

      // 0xEB is quad-only: in SPI mode it must be ignored
      beginTxn();
      sendByte(8'hEB);
      oeOr = 4'h0;
      for (int k = 0; k < 32; k++) begin
         applyStimulus(4'h0);
         oeOr = oeOr | smpOe[0];
      end
      endTxn();
      checkOutput("eb_in_spi_oe", oeOr, 4'h0);
      checkOutput("eb_in_spi_quad", quadMode[0], 1'b0);

      // 0x35 aborted after 4 bits leaves the mode alone
      beginTxn();
      applyStimulus(4'h0);
      applyStimulus(4'h0);
      applyStimulus(4'h1);
      applyStimulus(4'h1);
      endTxn();
      checkOutput("partial_35_quad", quadMode[0], 1'b0);

      singleCmd(8'h35);
      qpi = 1'b1;
      checkOutput("enter_qpi", quadMode[0], 1'b1);

      singleCmd(8'h99);
      checkOutput("rst_alone_quad", quadMode[0], 1'b1);

      // Quad write/read with latency sweep across the three instances
      beginTxn();
      sendByte(8'h38);
      sendAddr(24'h0000C8);
      sendByte(8'h12);
      sendByte(8'h34);
      sendByte(8'h56);
      endTxn();
      quadRead(24'h0000C8, 22);
      for (int d = 0; d < 3; d++) begin
         w = waitOf(d);
         oeOr = preOe[d];
         for (int u = 0; u < w - 1; u++) oeOr = oeOr | capOe[d][u];
         checkOutput($sformatf("wait_oe_w%0d", w), oeOr, 4'h0);
         checkOutput($sformatf("first_oe_w%0d", w), capOe[d][w-1], 4'hF);
         checkOutput($sformatf("quad_data_w%0d", w), nibbles(d, w - 1, 6), 32'h00123456);
      end

      // Wrap-around at the top of a 64 KiB memory, with an aliased address
      quadWrite(24'h12FFFF, 8'hFF, 8'hEE);
      quadRead(24'h00FFFF, 22);
      checkOutput("wrap_read_top", nibbles(0, 2, 4), 32'h0000FFEE);
      quadRead(24'h000000, 22);
      checkOutput("wrap_read_zero", nibbles(0, 2, 2), 32'h000000EE);

      // A partial byte at CSn rise must not be written
      quadWrite(24'h000020, 8'h00, 8'hAA);
      beginTxn();
      sendByte(8'h38);
      sendAddr(24'h000020);
      sendByte(8'h77);
      applyStimulus(4'h8);
      endTxn();
      quadRead(24'h000020, 22);
      checkOutput("partial_write", nibbles(0, 2, 4), 32'h000077AA);

      // Reset-enable flag is dropped by any other completed transaction
      singleCmd(8'h66);
      singleCmd(8'h00);
      singleCmd(8'h99);
      checkOutput("rsten_cleared", quadMode[0], 1'b1);

      singleCmd(8'h66);
      singleCmd(8'h99);
      qpi = 1'b0;
      checkOutput("rsten_rst_quad", quadMode[0], 1'b0);

      singleCmd(8'h35);
      qpi = 1'b1;
      checkOutput("reenter_qpi", quadMode[0], 1'b1);
      singleCmd(8'hF5);
      qpi = 1'b0;
      checkOutput("exit_qpi", quadMode[0], 1'b0);

      // RST pulse in the middle of a quad read
      singleCmd(8'h35);
      qpi = 1'b1;
      beginTxn();
      sendByte(8'hEB);
      sendAddr(24'h0000C8);
      applyStimulus(4'h0);
      applyStimulus(4'h0);
      applyStimulus(4'h0);
      checkOutput("rst_pre_oe", smpOe[0], 4'hF);
      RST = 1'b1;
      @(negedge CLK);
      checkOutput("rst_oe", ioOe[0], 4'h0);
      checkOutput("rst_quad", quadMode[0], 1'b0);
      RST = 1'b0;
      applyStimulus(4'h0);
      applyStimulus(4'h0);
      checkOutput("rst_idle_oe_w3", smpOe[0], 4'h0);
      checkOutput("rst_idle_oe_w1", smpOe[1], 4'h0);
      endTxn();
      qpi = 1'b0;

      singleCmd(8'h35);
      qpi = 1'b1;
      quadRead(24'h0000C8, 22);
      checkOutput("mem_retained", nibbles(0, 2, 6), 32'h00123456);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
